// File: rtl/store_commit_buffer_if.sv
// Commit-side and DCache-side signal bundle for the store commit buffer.
// No storage or latency of its own; it only groups wires.
// Flow control: sq_conflict pushes back on sq_en, dc_req_ready pushes back on dc_req_valid.
interface store_commit_buffer_if #(
    parameter int STORE_PIPELINE = 2,
    parameter int PADDR_SIZE     = 32,
    parameter int DCACHE_BYTE    = 4
);
    localparam int ADDR_W = PADDR_SIZE - $clog2(DCACHE_BYTE);
    localparam int DATA_W = DCACHE_BYTE * 8;

    // store queue commit port
    logic [STORE_PIPELINE-1:0]             sq_en;
    logic [STORE_PIPELINE*ADDR_W-1:0]      sq_addr;
    logic [STORE_PIPELINE*DCACHE_BYTE-1:0] sq_mask;
    logic [STORE_PIPELINE*DATA_W-1:0]      sq_data;
    logic                                  sq_conflict;

    // control and status
    logic                                  fence_req;
    logic                                  empty;

    // DCache write port
    logic                                  dc_req_valid;
    logic [ADDR_W-1:0]                     dc_req_addr;
    logic [DCACHE_BYTE-1:0]                dc_req_mask;
    logic [DATA_W-1:0]                     dc_req_data;
    logic                                  dc_req_ready;

    // environment side: store queue head plus DCache
    modport master (
        output sq_en, sq_addr, sq_mask, sq_data, fence_req, dc_req_ready,
        input  sq_conflict, empty, dc_req_valid, dc_req_addr, dc_req_mask, dc_req_data
    );

    // buffer side
    modport slave (
        input  sq_en, sq_addr, sq_mask, sq_data, fence_req, dc_req_ready,
        output sq_conflict, empty, dc_req_valid, dc_req_addr, dc_req_mask, dc_req_data
    );
endinterface

// File: rtl/store_commit_buffer.sv
// Coalescing buffer between store queue commit and the DCache write port; drains oldest-first.
// Accepted stores are visible one cycle later; a drain request appears one cycle after its trigger.
// sq_conflict rejects every lane when enabled lanes exceed free entries; dc_req_* holds until ready.
module store_commit_buffer #(
    parameter int STORE_PIPELINE = 2,
    parameter int DEPTH          = 8,
    parameter int PADDR_SIZE     = 32,
    parameter int DCACHE_BYTE    = 4,
    parameter int HIGH_WM        = 6,
    parameter int TIMEOUT        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    store_commit_buffer_if.slave bus
);
    localparam int ADDR_W = PADDR_SIZE - $clog2(DCACHE_BYTE);
    localparam int DATA_W = DCACHE_BYTE * 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_HWM = CNT_W'(HIGH_WM);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_ONE = 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    // entry storage; index is the low pointer bits, the pointer MSB is the wrap (dir) bit
    logic                   ent_vld  [DEPTH];
    logic [ADDR_W-1:0]      ent_addr [DEPTH];
    logic [DCACHE_BYTE-1:0] ent_mask [DEPTH];
    logic [DATA_W-1:0]      ent_data [DEPTH];

    logic                   nxt_vld  [DEPTH];
    logic [ADDR_W-1:0]      nxt_addr [DEPTH];
    logic [DCACHE_BYTE-1:0] nxt_mask [DEPTH];
    logic [DATA_W-1:0]      nxt_data [DEPTH];

    logic [PTR_W:0]         head_ptr;
    logic [PTR_W:0]         tail_ptr;
    logic [PTR_W:0]         head_nxt;
    logic [PTR_W:0]         tail_nxt;
    logic [PTR_W-1:0]       head_idx;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_nxt;
    logic [CNT_W-1:0]       en_cnt;
    logic [CNT_W-1:0]       free_cnt;
    logic [CNT_W-1:0]       alloc_cnt;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       timer_nxt;
    logic                   drain_q;
    logic                   drain_nxt;

    logic                   conflict;
    logic                   req_vld;
    logic                   hs;
    logic                   any_acc;
    logic                   trig;
    logic                   keep;
    logic                   hit;
    logic [PTR_W-1:0]       hit_idx;
    logic [PTR_W-1:0]       tgt;

    logic [STORE_PIPELINE-1:0] lane_acc;
    logic [ADDR_W-1:0]         lane_addr [STORE_PIPELINE];
    logic [DCACHE_BYTE-1:0]    lane_mask [STORE_PIPELINE];
    logic [DATA_W-1:0]         lane_data [STORE_PIPELINE];

    assign head_idx = head_ptr[PTR_W-1:0];

    // unpack the flat per-lane commit buses
    always_comb begin
        for (int i = 0; i < STORE_PIPELINE; i++) begin
            lane_addr[i] = bus.sq_addr[i*ADDR_W +: ADDR_W];
            lane_mask[i] = bus.sq_mask[i*DCACHE_BYTE +: DCACHE_BYTE];
            lane_data[i] = bus.sq_data[i*DATA_W +: DATA_W];
        end
    end

    // conservative admission: every enabled lane must fit a fresh entry, merges and same-cycle frees ignored
    always_comb begin
        en_cnt = '0;
        for (int i = 0; i < STORE_PIPELINE; i++) begin
            en_cnt = en_cnt + CNT_W'(bus.sq_en[i]);
        end
        free_cnt = CNT_MAX - count;
        conflict = (en_cnt > free_cnt);
        lane_acc = bus.sq_en & {STORE_PIPELINE{~conflict}};
    end

    // head request is live only while draining; the head entry is locked against merges meanwhile
    assign req_vld = drain_q & ent_vld[head_idx];
    assign hs      = req_vld & bus.dc_req_ready;

    // apply lanes in age order: merge into the unlocked same-word entry, else allocate at tail; then retire head
    always_comb begin
        nxt_vld   = ent_vld;
        nxt_addr  = ent_addr;
        nxt_mask  = ent_mask;
        nxt_data  = ent_data;
        tail_nxt  = tail_ptr;
        alloc_cnt = '0;
        any_acc   = 1'b0;
        hit       = 1'b0;
        hit_idx   = '0;
        tgt       = '0;
        for (int i = 0; i < STORE_PIPELINE; i++) begin
            hit     = 1'b0;
            hit_idx = '0;
            if (lane_acc[i]) begin
                any_acc = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if (!hit && nxt_vld[j] && (nxt_addr[j] == lane_addr[i]) &&
                        !(req_vld && (PTR_W'(j) == head_idx))) begin
                        hit     = 1'b1;
                        hit_idx = PTR_W'(j);
                    end
                end
                tgt = hit ? hit_idx : tail_nxt[PTR_W-1:0];
                if (!hit) begin
                    nxt_vld[tgt]  = 1'b1;
                    nxt_addr[tgt] = lane_addr[i];
                    nxt_mask[tgt] = '0;
                    nxt_data[tgt] = '0;
                    tail_nxt      = tail_nxt + PTR_ONE;
                    alloc_cnt     = alloc_cnt + CNT_ONE;
                end
                for (int b = 0; b < DCACHE_BYTE; b++) begin
                    if (lane_mask[i][b]) begin
                        nxt_data[tgt][b*8 +: 8] = lane_data[i][b*8 +: 8];
                    end
                end
                nxt_mask[tgt] = nxt_mask[tgt] | lane_mask[i];
            end
        end
        if (hs) begin
            nxt_vld[head_idx] = 1'b0;
        end
    end

    // occupancy, head advance, idle timer and drain latch
    always_comb begin
        head_nxt  = hs ? (head_ptr + PTR_ONE) : head_ptr;
        count_nxt = count + alloc_cnt - CNT_W'(hs);

        if (any_acc || hs || (count == '0)) begin
            timer_nxt = '0;
        end else if (!req_vld && (timer != TMR_MAX)) begin
            timer_nxt = timer + TMR_ONE;
        end else begin
            timer_nxt = timer;
        end

        trig = (count >= CNT_HWM) || (timer == TMR_MAX) || bus.fence_req;
        // after a handshake keep going while above the watermark, fenced, or entries remain
        keep = (count > CNT_HWM) || bus.fence_req || (count > CNT_ONE);

        drain_nxt = drain_q;
        if (hs) begin
            drain_nxt = keep;
        end else if (count == '0) begin
            drain_nxt = 1'b0;
        end else if (!req_vld && trig) begin
            drain_nxt = 1'b1;
        end
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            timer    <= '0;
            drain_q  <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                ent_vld[j] <= 1'b0;
            end
        end else begin
            head_ptr <= head_nxt;
            tail_ptr <= tail_nxt;
            count    <= count_nxt;
            timer    <= timer_nxt;
            drain_q  <= drain_nxt;
            for (int j = 0; j < DEPTH; j++) begin
                ent_vld[j] <= nxt_vld[j];
            end
        end
    end

    // entry payload; qualified by ent_vld so it needs no reset
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_addr[j] <= nxt_addr[j];
            ent_mask[j] <= nxt_mask[j];
            ent_data[j] <= nxt_data[j];
        end
    end

    assign bus.sq_conflict  = conflict;
    assign bus.empty        = (count == '0);
    assign bus.dc_req_valid = req_vld;
    assign bus.dc_req_addr  = ent_addr[head_idx];
    assign bus.dc_req_mask  = ent_mask[head_idx];
    assign bus.dc_req_data  = ent_data[head_idx];
endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;
    localparam int AW = 30;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    wr_t  exp_q[$];

    store_commit_buffer_if #(.STORE_PIPELINE(2), .PADDR_SIZE(32), .DCACHE_BYTE(4)) bus ();

    store_commit_buffer #(
        .STORE_PIPELINE(2), .DEPTH(8), .PADDR_SIZE(32), .DCACHE_BYTE(4),
        .HIGH_WM(6), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.sq_en = '0;
    endtask

    task automatic put(input int ln, input logic [AW-1:0] a, input logic [3:0] m, input logic [7:0] b);
        bus.sq_en[ln]             = 1'b1;
        bus.sq_addr[ln*AW +: AW]  = a;
        bus.sq_mask[ln*4 +: 4]    = m;
        bus.sq_data[ln*32 +: 32]  = {4{b}};
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.mask = m;
        e.data = d & byte_mask(m);
        exp_q.push_back(e);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        int k = 0;
        while (!(bus.empty === 1'b1 && bus.dc_req_valid === 1'b0) && k < budget) begin
            cyc();
            k++;
        end
        check(tag, 64'({bus.empty, bus.dc_req_valid}), 64'b10);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (bus.dc_req_valid !== 1'b1 && k < budget) begin
            cyc();
            k++;
        end
        check(tag, 64'(bus.dc_req_valid), 64'd1);
    endtask

    // scoreboard: every DCache handshake pops the oldest expected write
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.dc_req_valid === 1'b1 && bus.dc_req_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(bus.dc_req_addr), 64'(e.addr));
                check("wr_mask", 64'(bus.dc_req_mask), 64'(e.mask));
                check("wr_data", 64'(bus.dc_req_data & byte_mask(e.mask)), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hs_n;
        int first;
        int last;

        bus.sq_en        = '0;
        bus.sq_addr      = '0;
        bus.sq_mask      = '0;
        bus.sq_data      = '0;
        bus.fence_req    = 1'b0;
        bus.dc_req_ready = 1'b0;

        // reset state
        rst = 1'b1;
        cyc();
        cyc();
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_valid", 64'(bus.dc_req_valid), 64'd0);
        check("rst_conflict", 64'(bus.sq_conflict), 64'd0);
        check("rst_count", 64'(dut.count), 64'd0);
        rst = 1'b0;

        // single store drains on the idle timeout
        bus.dc_req_ready = 1'b1;
        put(0, 30'h100, 4'b0001, 8'hAA);
        expect_wr(30'h100, 4'b0001, 32'hAAAAAAAA);
        cyc();
        idle_in();
        check("t1_not_empty", 64'(bus.empty), 64'd0);
        check("t1_no_early_req", 64'(bus.dc_req_valid), 64'd0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (bus.dc_req_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("t1_latency", 64'(lat), 64'd16);
        check("t1_addr", 64'(bus.dc_req_addr), 64'h100);
        check("t1_mask", 64'(bus.dc_req_mask), 64'b0001);
        cyc();
        check("t1_empty_after", 64'(bus.empty), 64'd1);
        check("t1_valid_after", 64'(bus.dc_req_valid), 64'd0);

        // two lanes to the same word coalesce, lane 1 wins overlapping bytes
        put(0, 30'h40, 4'b0011, 8'h11);
        put(1, 30'h40, 4'b0110, 8'h22);
        expect_wr(30'h40, 4'b0111, 32'h00222211);
        cyc();
        idle_in();
        check("t2_count", 64'(dut.count), 64'd1);
        bus.fence_req = 1'b1;
        wait_empty("t2_drained", 40);
        bus.fence_req = 1'b0;

        // fill with distinct words, no ready: watermark start and all-or-nothing conflict
        bus.dc_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            put(0, 30'(32'h200 + i), 4'b1111, 8'(8'h10 + i));
            expect_wr(30'(32'h200 + i), 4'b1111, {4{8'(8'h10 + i)}});
            cyc();
            idle_in();
        end
        check("t3_count6", 64'(dut.count), 64'd6);
        check("t3_no_req_yet", 64'(bus.dc_req_valid), 64'd0);
        put(0, 30'h206, 4'b1111, 8'h16);
        expect_wr(30'h206, 4'b1111, 32'h16161616);
        cyc();
        idle_in();
        check("t3_count7", 64'(dut.count), 64'd7);
        check("t3_req_started", 64'(bus.dc_req_valid), 64'd1);
        check("t3_req_addr", 64'(bus.dc_req_addr), 64'h200);
        put(0, 30'h207, 4'b1111, 8'h17);
        put(1, 30'h208, 4'b1111, 8'h18);
        #1;
        check("t3_conflict2", 64'(bus.sq_conflict), 64'd1);
        cyc();
        idle_in();
        check("t3_count_held", 64'(dut.count), 64'd7);
        put(0, 30'h207, 4'b1111, 8'h17);
        #1;
        check("t3_conflict1", 64'(bus.sq_conflict), 64'd0);
        expect_wr(30'h207, 4'b1111, 32'h17171717);
        cyc();
        idle_in();
        check("t3_count8", 64'(dut.count), 64'd8);
        check("t3_req_stable", 64'({bus.dc_req_valid, bus.dc_req_addr}), {33'd0, 1'b1, 30'h200});
        put(0, 30'h209, 4'b1111, 8'h19);
        #1;
        check("t3_conflict_full", 64'(bus.sq_conflict), 64'd1);
        cyc();
        idle_in();
        check("t3_count_full", 64'(dut.count), 64'd8);
        bus.dc_req_ready = 1'b1;
        wait_empty("t3_drained", 60);

        // locked head is not merged into; a second entry for the same word is allocated
        bus.dc_req_ready = 1'b0;
        put(0, 30'h80, 4'b0001, 8'h33);
        expect_wr(30'h80, 4'b0001, 32'h33333333);
        cyc();
        idle_in();
        bus.fence_req = 1'b1;
        wait_valid("t4_req", 10);
        bus.fence_req = 1'b0;
        check("t4_head_addr", 64'(bus.dc_req_addr), 64'h80);
        put(0, 30'h80, 4'b0010, 8'h44);
        expect_wr(30'h80, 4'b0010, 32'h44444444);
        cyc();
        idle_in();
        check("t4_no_merge_count", 64'(dut.count), 64'd2);
        check("t4_head_mask_stable", 64'(bus.dc_req_mask), 64'b0001);
        bus.dc_req_ready = 1'b1;
        bus.fence_req    = 1'b1;
        wait_empty("t4_drained", 40);
        bus.fence_req = 1'b0;

        // fence with three entries drains them back-to-back
        bus.dc_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(0, 30'(32'h300 + i), 4'b1000, 8'(8'h30 + i));
            expect_wr(30'(32'h300 + i), 4'b1000, {4{8'(8'h30 + i)}});
            cyc();
            idle_in();
        end
        check("t5_count3", 64'(dut.count), 64'd3);
        bus.dc_req_ready = 1'b1;
        bus.fence_req    = 1'b1;
        hs_n  = 0;
        first = -1;
        last  = -1;
        for (int k = 0; k < 12; k++) begin
            if (bus.dc_req_valid === 1'b1) begin
                hs_n++;
                if (first < 0) first = k;
                last = k;
            end
            cyc();
        end
        bus.fence_req = 1'b0;
        check("t5_handshakes", 64'(hs_n), 64'd3);
        check("t5_back_to_back", 64'(last - first), 64'd2);
        check("t5_empty", 64'(bus.empty), 64'd1);
        check("t5_valid_low", 64'(bus.dc_req_valid), 64'd0);

        // reset in the middle of a pending request
        bus.dc_req_ready = 1'b0;
        put(0, 30'h500, 4'b1111, 8'h50);
        cyc();
        idle_in();
        put(0, 30'h501, 4'b1111, 8'h51);
        cyc();
        idle_in();
        bus.fence_req = 1'b1;
        wait_valid("t6_req", 10);
        bus.fence_req = 1'b0;
        rst = 1'b1;
        cyc();
        check("t6_valid", 64'(bus.dc_req_valid), 64'd0);
        check("t6_count", 64'(dut.count), 64'd0);
        check("t6_head", 64'(dut.head_ptr), 64'd0);
        check("t6_tail", 64'(dut.tail_ptr), 64'd0);
        check("t6_empty", 64'(bus.empty), 64'd1);
        rst = 1'b0;
        cyc();

        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Receives committed stores from the store queue's commit port: per-lane en/addr/mask/data in, conflict back.
- Holds them in a small coalescing buffer that merges same-word stores.
- Drains entries oldest-first to the DCache write port over a valid/ready handshake.
- Sits between the store queue head and the DCache; provides the back-pressure (conflict) that stalls the store queue head.

Parameters:
- STORE_PIPELINE, 2, commit lanes from store queue (lane i+1 is younger than lane i)
- DEPTH, 8, buffer entries (power of 2)
- PADDR_SIZE, 32, physical address width
- DCACHE_BYTE, 4, bytes per word; ADDR_W = PADDR_SIZE - log2(DCACHE_BYTE)
- HIGH_WM, 6, occupancy at or above which draining starts
- TIMEOUT, 16, idle cycles with a non-empty buffer before draining starts

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sq_en  in  STORE_PIPELINE  per-lane commit valid
- sq_addr  in  STORE_PIPELINE*ADDR_W  word address per lane
- sq_mask  in  STORE_PIPELINE*DCACHE_BYTE  byte enables per lane
- sq_data  in  STORE_PIPELINE*DCACHE_BYTE*8  byte-replicated data per lane
- sq_conflict  out  1  reject all lanes this cycle; store queue holds its head
- fence_req  in  1  force drain until empty
- empty  out  1  no valid entries
- dc_req_valid  out  1  DCache write request
- dc_req_addr  out  ADDR_W  word address
- dc_req_mask  out  DCACHE_BYTE  byte enables
- dc_req_data  out  DCACHE_BYTE*8  write data
- dc_req_ready  in  1  DCache accepts request

Behaviour:
- Storage: circular buffer; head/tail of log2(DEPTH) bits plus a dir bit each; count = occupancy register (0..DEPTH).
- Reset (sync): head = tail = count = 0, dirs = 0, all entry valid = 0, drain latch = 0, timer = 0. Outputs: dc_req_valid = 0, empty = 1, sq_conflict = 0.
- sq_conflict (combinational) = popcount(sq_en) > DEPTH - count, using the registered count.
  - Conservative: merge opportunities are ignored.
  - Frees from a same-cycle drain do not help.
  - All-or-nothing: when conflict = 1, no lane is written.
- Lock: the head entry is locked while dc_req_valid = 1.
- Acceptance (sq_en[i] & ~sq_conflict), lanes processed in order 0, 1.
  - Merge target: the valid, unlocked entry with equal addr. At most one exists by construction.
  - If a target exists: bytes with mask = 1 overwrite the entry's bytes; entry mask |= lane mask.
  - If no target: allocate at tail, tail + 1, count + 1.
  - Lane 1 sees lane 0's same-cycle effect. Same addr on both lanes gives one entry, with lane 1 bytes winning where the masks overlap.
- Entry updates become visible the cycle after acceptance.
- Drain start: the drain latch sets when no request is pending, count > 0, and any of:
  - count >= HIGH_WM
  - timer == TIMEOUT-1
  - fence_req
- dc_req_valid = drain latch & valid[head]. dc_req_addr/mask/data = head entry contents.
- Request stability: once dc_req_valid = 1, it and the payload stay constant until dc_req_ready. No merges into the head entry during this time.
- On handshake (valid & ready):
  - clear valid[head]; head + 1; count - 1.
  - The drain latch stays set while count - 1 >= HIGH_WM, or fence_req, or the entry just freed was not the last; otherwise it clears.
  - Effect: once started, draining continues back-to-back until the trigger condition no longer holds.
- Same cycle allocate and drain: count = count + allocs - 1.
- Wrap-around: on pointer increment from DEPTH-1 to 0, the pointer's dir bit toggles. Full means head == tail with dirs different; empty means equal.
- Timer: increments while count > 0 & ~dc_req_valid; clears on any accepted lane, on handshake, or when count == 0; saturates at TIMEOUT-1.
- empty = (count == 0). Registered-state derived, so it drops the cycle after the first allocation.
- Ordering: entries leave the buffer strictly in allocation order. A merge never moves an entry.

Test Plan:
- Reset, then lane0 addr 0x100, mask 0001, data 0xAA; dc_req_ready = 1 → no request for 15 cycles; dc_req_valid asserted at timer 15 with addr 0x100, mask 0001; empty = 1 one cycle after the handshake.
- Same cycle: lane0 addr 0x40, mask 0011, data 0x1111; lane1 addr 0x40, mask 0110, data 0x2222 → one entry, count 1, mask 0111, bytes [2:0] = 22,22,11.
- Fill 8 distinct addrs with dc_req_ready = 0 → draining starts at count 6; at count 7, two enables give sq_conflict = 1 and count stays 7; one enable is accepted.
- Locked head: head addr 0x80 presented with ready = 0; new store to 0x80 → allocates a new entry, does not merge; DCache later sees two writes to 0x80 in order.
- fence_req with count 3 → three back-to-back handshakes with ready = 1; empty = 1 afterwards; dc_req_valid = 0.
- Assert rst mid-drain with dc_req_valid = 1 → next cycle dc_req_valid = 0, count 0, head = tail = 0.
